// File: rtl/jpeg_bitstream_packer_if.sv
// Codeword-in / byte-out bundle for the JPEG entropy-coded bitstream packer.
// The packer takes the slave view; the encoder/sink side takes the master view.
interface jpeg_bitstream_packer_if #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned CNT_W   = 24
);
    logic               in_valid;
    logic               in_ready;
    logic [MAX_LEN-1:0] in_code;
    logic [5:0]         in_len;
    logic               flush_req;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_byte;
    logic               out_last;
    logic               flush_done;
    logic [CNT_W-1:0]   bytes_out;
    logic               err_len;

    modport master (
        output in_valid, in_code, in_len, flush_req, out_ready,
        input  in_ready, out_valid, out_byte, out_last, flush_done, bytes_out, err_len
    );

    modport slave (
        input  in_valid, in_code, in_len, flush_req, out_ready,
        output in_ready, out_valid, out_byte, out_last, flush_done, bytes_out, err_len
    );
endinterface

// File: rtl/jpeg_bitstream_packer.sv
// Packs right-aligned variable-length codewords MSB-first into a JPEG entropy-coded byte stream,
// inserting 0x00 after every emitted 0xFF and padding with 1s to a byte boundary on flush.
module jpeg_bitstream_packer #(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned ACC_W   = 64,
    parameter int unsigned CNT_W   = 24
) (
    input logic                    clock,
    input logic                    reset_n,
    jpeg_bitstream_packer_if.slave bus
);
    localparam int unsigned     BC_W     = $clog2(ACC_W + 1);
    localparam logic [BC_W-1:0] ReadyMax = BC_W'(ACC_W - MAX_LEN);
    localparam logic [BC_W-1:0] AccBits  = BC_W'(ACC_W);
    localparam logic [BC_W-1:0] ByteBits = BC_W'(8);
    localparam logic [5:0]      MaxLen   = 6'(MAX_LEN);

    typedef enum logic [1:0] {StRun, StPad, StDrain} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             stuff_pend_q, stuff_pend_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] bytes_out_q;
    logic             err_len_q;

    logic             emit, data_emit, top_is_ff, take, len_bad, len_ok;
    logic [ACC_W-1:0] acc_shift, ins_bits, code_ext;
    logic [BC_W-1:0]  cnt_after, ins_len, ins_shamt;
    logic [2:0]       pad_len;

    assign top_is_ff = (acc_q[ACC_W-1 -: 8] == 8'hFF);
    assign emit      = bus.out_valid && bus.out_ready;
    assign data_emit = emit && !stuff_pend_q;
    assign take      = bus.in_valid && in_ready_q;
    assign len_bad   = (bus.in_len > MaxLen);
    assign len_ok    = take && (bus.in_len != 6'd0) && !len_bad;
    assign code_ext  = ACC_W'(bus.in_code);

    always_comb begin
        acc_shift = data_emit ? (acc_q << 8) : acc_q;
        cnt_after = data_emit ? (bit_cnt_q - ByteBits) : bit_cnt_q;
        // Pad count is taken after any same-cycle emit so the pad lands on the true tail.
        pad_len   = 3'd0 - cnt_after[2:0];
        ins_len   = '0;
        ins_bits  = '0;
        if (state_q == StRun && len_ok) begin
            ins_len  = BC_W'(bus.in_len);
            ins_bits = code_ext & ~({ACC_W{1'b1}} << bus.in_len);
        end else if (state_q == StPad) begin
            ins_len  = BC_W'(pad_len);
            ins_bits = ~({ACC_W{1'b1}} << pad_len);
        end
        ins_shamt = AccBits - cnt_after - ins_len;
        acc_d     = acc_shift | (ins_bits << ins_shamt);
        bit_cnt_d = cnt_after + ins_len;

        stuff_pend_d = stuff_pend_q;
        if (data_emit && top_is_ff) begin
            stuff_pend_d = 1'b1;
        end else if (emit && stuff_pend_q) begin
            stuff_pend_d = 1'b0;
        end

        state_d = state_q;
        unique case (state_q)
            StRun:   if (bus.flush_req) state_d = StPad;
            StPad:   state_d = StDrain;
            StDrain: if (bit_cnt_q == '0 && !stuff_pend_q) state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRun;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            stuff_pend_q <= 1'b0;
            in_ready_q   <= 1'b0;
            bytes_out_q  <= '0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            stuff_pend_q <= stuff_pend_d;
            // Ready is looked ahead from next state so it never depends on out_ready combinationally.
            in_ready_q   <= (state_d == StRun) && (bit_cnt_d <= ReadyMax);
            if (emit) begin
                bytes_out_q <= bytes_out_q + CNT_W'(1);
            end
            if (take && len_bad) begin
                err_len_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (bit_cnt_q >= ByteBits) || stuff_pend_q;
    assign bus.out_byte   = stuff_pend_q ? 8'h00 : acc_q[ACC_W-1 -: 8];
    // Final byte of a drain; if it is 0xFF the trailing stuffed 0x00 carries the flag instead.
    assign bus.out_last   = (state_q == StDrain) &&
                            (stuff_pend_q ? (bit_cnt_q == '0)
                                          : (bit_cnt_q == ByteBits && !top_is_ff));
    assign bus.flush_done = (state_q == StDrain) && (bit_cnt_q == '0) && !stuff_pend_q;
    assign bus.bytes_out  = bytes_out_q;
    assign bus.err_len    = err_len_q;
endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Bench for jpeg_bitstream_packer: flush vectors from a table, a bit-level golden packer for
// streaming, and directed reset / error / empty-flush sequences, all checked via a byte scoreboard.
module tb_jpeg_bitstream_packer;
    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned ACC_W   = 64;
    localparam int unsigned CNT_W   = 24;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    jpeg_bitstream_packer_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    jpeg_bitstream_packer #(
        .MAX_LEN(MAX_LEN),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [31:0] c0;
        logic [5:0]  l0;
        logic [31:0] c1;
        logic [5:0]  l1;
        int          n;
        logic [63:0] exp_bytes;
    } vec_t;

    exp_t        exp_q[$];
    bit          bitq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned exp_total = 0;
    int unsigned ready_mode = 0;  // 0 hold low, 1 hold high, 2 random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Sole driver of out_ready; runs after the main thread's +1 updates.
    always @(posedge clock) begin
        #2;
        if (ready_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
        else                 bus.out_ready = (ready_mode == 1);
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_byte: got 0x%0h, want no byte", bus.out_byte);
            end else begin
                e = exp_q.pop_front();
                check("out_byte", 64'(bus.out_byte), 64'(e.data));
                check("out_last", 64'(bus.out_last), 64'(e.last));
            end
        end
    end

    task automatic model_drain();
        logic [7:0] b;
        while (bitq.size() >= 8) begin
            for (int i = 7; i >= 0; i--) b[i] = bitq.pop_front();
            exp_q.push_back('{data: b, last: 1'b0});
            exp_total++;
            if (b == 8'hFF) begin
                exp_q.push_back('{data: 8'h00, last: 1'b0});
                exp_total++;
            end
        end
    endtask

    task automatic model_push(input logic [31:0] c, input logic [5:0] l);
        if (l == 6'd0 || l > 6'd32) return;
        for (int i = int'(l) - 1; i >= 0; i--) bitq.push_back(c[i]);
        model_drain();
    endtask

    // Used only while out_ready is held low, so the queue tail is still inside the packer.
    task automatic model_flush();
        while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
        model_drain();
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
    endtask

    task automatic send_code(input logic [31:0] c, input logic [5:0] l, input bit use_model);
        int guard = 0;
        bit rdy = 1'b0;
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        bus.in_len   = l;
        while (!ok && guard < 200) begin
            @(negedge clock);
            rdy = bus.in_ready;
            @(posedge clock);
            #1;
            guard++;
            if (rdy) ok = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (ok && use_model) model_push(c, l);
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, want 1");
        end
    endtask

    task automatic do_flush(input bit release_ready, input bit use_model);
        if (use_model) model_flush();
        bus.flush_req = 1'b1;
        @(posedge clock);
        #1;
        bus.flush_req = 1'b0;
        @(posedge clock);
        #1;
        if (release_ready) ready_mode = 1;
    endtask

    task automatic wait_flush_done(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clock);
            if (bus.flush_done) seen = 1'b1;
            @(posedge clock);
            #1;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    vec_t vec[9];

    initial begin
        logic [15:0] words[4];
        logic [31:0] wd;
        int          acc_n;
        bit          rdy;

        vec[0] = '{32'h0000_0005, 6'd3,  32'h0,         6'd0,  1, 64'hBF00_0000_0000_0000};
        vec[1] = '{32'h0000_00FF, 6'd8,  32'h0000_000A, 6'd4,  3, 64'hFF00_AF00_0000_0000};
        vec[2] = '{32'h0000_FFFF, 6'd16, 32'h0,         6'd0,  4, 64'hFF00_FF00_0000_0000};
        vec[3] = '{32'h0000_0012, 6'd8,  32'h0,         6'd0,  1, 64'h1200_0000_0000_0000};
        vec[4] = '{32'hFFFF_FFFE, 6'd1,  32'h0,         6'd0,  1, 64'h7F00_0000_0000_0000};
        vec[5] = '{32'hDEAD_BEE3, 6'd2,  32'h1234_567F, 6'd6,  2, 64'hFF00_0000_0000_0000};
        vec[6] = '{32'hFFFF_FFFF, 6'd32, 32'h0,         6'd0,  8, 64'hFF00_FF00_FF00_FF00};
        vec[7] = '{32'hFFFF_FF81, 6'd8,  32'hFFFA_BCDE, 6'd20, 4, 64'h81AB_CDEF_0000_0000};
        vec[8] = '{32'hFFFF_FFFF, 6'd0,  32'h0000_0005, 6'd3,  1, 64'hBF00_0000_0000_0000};
        words  = '{16'hFFA5, 16'h12FF, 16'hC3C3, 16'hFFFF};

        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_len    = '0;
        bus.flush_req = 1'b0;
        reset_n       = 1'b1;
        #1 reset_n    = 1'b0;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready",   64'(bus.in_ready),   64'd0);
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_out_byte",   64'(bus.out_byte),   64'd0);
        check("rst_out_last",   64'(bus.out_last),   64'd0);
        check("rst_flush_done", 64'(bus.flush_done), 64'd0);
        check("rst_bytes_out",  64'(bus.bytes_out),  64'd0);
        check("rst_err_len",    64'(bus.err_len),    64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2);
        @(negedge clock);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        idle(1);

        // Flush vectors: codewords loaded with the sink stalled, then drained in one burst
        for (int v = 0; v < 9; v++) begin
            ready_mode = 0;
            idle(1);
            send_code(vec[v].c0, vec[v].l0, 1'b0);
            if (vec[v].l1 != 6'd0) send_code(vec[v].c1, vec[v].l1, 1'b0);
            for (int i = 0; i < vec[v].n; i++)
                exp_q.push_back('{data: vec[v].exp_bytes[63-8*i -: 8], last: (i == vec[v].n - 1)});
            exp_total += vec[v].n;
            do_flush(1'b1, 1'b0);
            wait_flush_done($sformatf("vec%0d_flush_done", v));
            check($sformatf("vec%0d_drained", v), 64'(exp_q.size()), 64'd0);
            check($sformatf("vec%0d_bytes_out", v), 64'(bus.bytes_out), 64'(exp_total));
        end

        // Empty flush: PAD then DRAIN, flush_done two cycles after the request
        ready_mode = 1;
        idle(2);
        bus.flush_req = 1'b1;
        @(posedge clock);
        #1 bus.flush_req = 1'b0;
        @(negedge clock);
        check("empty_pad_flush_done", 64'(bus.flush_done), 64'd0);
        check("empty_pad_in_ready",   64'(bus.in_ready),   64'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("empty_flush_done",  64'(bus.flush_done), 64'd1);
        check("empty_out_valid",   64'(bus.out_valid),  64'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("empty_done_pulse",  64'(bus.flush_done), 64'd0);
        check("empty_in_ready",    64'(bus.in_ready),   64'd1);
        check("empty_bytes_out",   64'(bus.bytes_out),  64'(exp_total));
        idle(1);

        // Zero-length and over-length codewords
        send_code(32'hFFFF_FFFF, 6'd0, 1'b1);
        idle(3);
        check("len0_err_len", 64'(bus.err_len), 64'd0);
        send_code(32'hFFFF_FFFF, 6'd33, 1'b1);
        idle(4);
        check("len33_err_len",   64'(bus.err_len),   64'd1);
        check("len33_bytes_out", 64'(bus.bytes_out), 64'(exp_total));
        ready_mode = 0;
        idle(1);
        send_code(32'h0000_0005, 6'd3, 1'b1);
        do_flush(1'b1, 1'b1);
        wait_flush_done("err_flush_done");
        check("err_sticky", 64'(bus.err_len), 64'd1);
        check("err_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: 16-bit words with the sink stalled until in_ready drops
        ready_mode = 0;
        idle(1);
        acc_n        = 0;
        bus.in_valid = 1'b1;
        bus.in_len   = 6'd16;
        bus.in_code  = {16'hDEAD, words[0]};
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            rdy = bus.in_ready;
            @(posedge clock);
            #1;
            if (rdy) begin
                model_push(bus.in_code, 6'd16);
                acc_n++;
                bus.in_code = {16'hDEAD, words[acc_n]};
            end
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 64'(acc_n), 64'd3);
        @(negedge clock);
        check("bp_in_ready",  64'(bus.in_ready),  64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_out_byte",  64'(bus.out_byte),  64'(exp_q[0].data));
        @(posedge clock);
        #1;
        @(negedge clock);
        check("bp_hold_byte", 64'(bus.out_byte),  64'(exp_q[0].data));
        @(posedge clock);
        #1;
        ready_mode = 2;
        send_code({16'hBEEF, words[3]}, 6'd16, 1'b1);
        for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 2));
            wd = $urandom;
            send_code(wd, 6'($urandom_range(1, 32)), 1'b1);
        end
        ready_mode = 1;
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) idle(1);
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        ready_mode = 0;
        idle(2);
        do_flush(1'b1, 1'b1);
        wait_flush_done("stream_flush_done");
        check("stream_flush_drained", 64'(exp_q.size()), 64'd0);
        check("stream_bytes_out", 64'(bus.bytes_out), 64'(exp_total));

        // Reset while draining three bytes
        ready_mode = 0;
        idle(1);
        send_code(32'h00A1_B2C3, 6'd24, 1'b0);
        do_flush(1'b0, 1'b0);
        @(negedge clock);
        check("mid_drain_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clock);
        #1 reset_n = 1'b0;
        exp_q.delete();
        bitq.delete();
        exp_total = 0;
        @(negedge clock);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_bytes_out", 64'(bus.bytes_out), 64'd0);
        check("mid_rst_err_len",   64'(bus.err_len),   64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2);
        send_code(32'h0000_0012, 6'd8, 1'b1);
        do_flush(1'b1, 1'b1);
        wait_flush_done("post_rst_flush_done");
        check("post_rst_drained",   64'(exp_q.size()),   64'd0);
        check("post_rst_bytes_out", 64'(bus.bytes_out), 64'd1);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish by 3 ms, want finish");
        $fatal(1);
    end
endmodule
